credit_counter_array: RTL and testbench

Multi-channel, parametrised credit counter for the latency-insensitive FIR channels. One independent credit counter per channel gates the channel's sender-FIFO pops against downstream buffer space. Each channel returns multiple credits per cycle, nets a simultaneous consume and return, and clamps on overflow with an optional sticky error. It sits between the per-channel sender FIFOs and the relay-station links.

---
 rtl/credit_pkg.sv | 17 +
 rtl/credit_channel.sv | 80 ++++++++
 rtl/credit_counter_array.sv | 42 ++++
 tb/tb_credit_counter_array.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared defaults, types and helpers for the per-channel credit counters.
// Optional feature macro: CREDIT_OVERFLOW_CHECK_EN (sticky overflow flag).
package credit_pkg;

  localparam int unsigned N_CHANNELS_DEF = 4;
  localparam int unsigned N_CREDITS_DEF  = 10;
  localparam int unsigned RET_W_DEF      = 2;
  localparam int unsigned LOW_THRESH_DEF = 2;

  typedef logic [RET_W_DEF-1:0] credit_ret_t;

  // Bits needed to hold a count in the range 0..n.
  function automatic int unsigned credit_cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/credit_channel.sv
// One channel's credit counter: consume/return netting, clamp at the maximum,
// and registered ready/valid/low flags.
// Optional feature macro: CREDIT_OVERFLOW_CHECK_EN (sticky overflow flag).
module credit_channel
  import credit_pkg::*;
#(
  parameter  int unsigned N_CREDITS  = N_CREDITS_DEF,
  parameter  int unsigned RET_W      = RET_W_DEF,
  parameter  int unsigned LOW_THRESH = LOW_THRESH_DEF,
  localparam int unsigned CNT_W      = credit_cnt_width(N_CREDITS),
  localparam int unsigned SUM_W      = CNT_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_fifo_empty,
  input  logic [RET_W-1:0] i_credit_return,
  output logic             o_ready,
  output logic             o_valid,
  output logic             o_low,
  output logic [CNT_W-1:0] o_credit_count,
  output logic             o_overflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_ready;
  logic             r_valid;
  logic             r_low;

  logic             w_consume;
  logic [SUM_W-1:0] w_sum;
  logic             w_clamp;
  logic [CNT_W-1:0] w_next;

  // Next count: a pop is only possible with credit in hand; returns land together with it.
  always_comb begin
    w_consume = !i_fifo_empty && (r_count != '0);
    w_sum     = SUM_W'(r_count) - SUM_W'(w_consume) + SUM_W'(i_credit_return);
    w_clamp   = (w_sum > SUM_W'(N_CREDITS));
    w_next    = w_clamp ? CNT_W'(N_CREDITS) : CNT_W'(w_sum);
  end

  // Count register and flags derived from the value being loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= CNT_W'(N_CREDITS);
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_low   <= (N_CREDITS <= LOW_THRESH);
    end else begin
      r_count <= w_next;
      r_ready <= (w_next != '0);
      r_valid <= w_consume;
      r_low   <= (32'(w_next) <= LOW_THRESH);
    end
  end

`ifdef CREDIT_OVERFLOW_CHECK_EN
  logic r_overflow;

  // Sticky record of any return that would have pushed the count past the maximum.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_clamp) begin
      r_overflow <= 1'b1;
      $error("credit overflow in channel %m: sum=%0d", w_sum);
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_ready        = r_ready;
  assign o_valid        = r_valid;
  assign o_low          = r_low;
  assign o_credit_count = r_count;

endmodule

// File: rtl/credit_counter_array.sv
// Array of independent credit counters gating sender-FIFO pops per channel.
// Optional feature macro: CREDIT_OVERFLOW_CHECK_EN (sticky overflow flag).
module credit_counter_array
  import credit_pkg::*;
#(
  parameter  int unsigned N_CHANNELS = N_CHANNELS_DEF,
  parameter  int unsigned N_CREDITS  = N_CREDITS_DEF,
  parameter  int unsigned RET_W      = RET_W_DEF,
  parameter  int unsigned LOW_THRESH = LOW_THRESH_DEF,
  localparam int unsigned CNT_W      = credit_cnt_width(N_CREDITS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CHANNELS-1:0]       i_fifo_empty,
  input  logic [N_CHANNELS*RET_W-1:0] i_credit_return,
  output logic [N_CHANNELS-1:0]       o_ready,
  output logic [N_CHANNELS-1:0]       o_valid,
  output logic [N_CHANNELS-1:0]       o_low,
  output logic [N_CHANNELS*CNT_W-1:0] o_credit_count,
  output logic [N_CHANNELS-1:0]       o_overflow
);

  // One counter per channel; the top only slices the buses.
  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_chan
    credit_channel #(
      .N_CREDITS  (N_CREDITS),
      .RET_W      (RET_W),
      .LOW_THRESH (LOW_THRESH)
    ) u_chan (
      .clock           (clock),
      .reset           (reset),
      .i_fifo_empty    (i_fifo_empty[c]),
      .i_credit_return (i_credit_return[c*RET_W +: RET_W]),
      .o_ready         (o_ready[c]),
      .o_valid         (o_valid[c]),
      .o_low           (o_low[c]),
      .o_credit_count  (o_credit_count[c*CNT_W +: CNT_W]),
      .o_overflow      (o_overflow[c])
    );
  end

endmodule

// File: tb/tb_credit_counter_array.sv
// Scoreboard bench for credit_counter_array with default parameters.
// Honours CREDIT_OVERFLOW_CHECK_EN when expecting o_overflow.
module tb_credit_counter_array;

  logic        clock;
  logic        reset;
  logic [3:0]  i_fifo_empty;
  logic [7:0]  i_credit_return;
  logic [3:0]  o_ready;
  logic [3:0]  o_valid;
  logic [3:0]  o_low;
  logic [15:0] o_credit_count;
  logic [3:0]  o_overflow;

  typedef struct packed {
    logic [3:0]  ready;
    logic [3:0]  valid;
    logic [3:0]  low;
    logic [3:0]  ovf;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   m_count[4];
  bit   m_ovf[4];
  int   checks   = 0;
  int   failures = 0;

`ifdef CREDIT_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  credit_counter_array dut (
    .clock           (clock),
    .reset           (reset),
    .i_fifo_empty    (i_fifo_empty),
    .i_credit_return (i_credit_return),
    .o_ready         (o_ready),
    .o_valid         (o_valid),
    .o_low           (o_low),
    .o_credit_count  (o_credit_count),
    .o_overflow      (o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t got_now();
    return {o_ready, o_valid, o_low, o_overflow, o_credit_count};
  endfunction

  // Drive one cycle, push the expected post-edge outputs, advance past the edge.
  task automatic drive(input logic rst, input logic [3:0] empty, input logic [7:0] ret);
    exp_t e;
    reset           = rst;
    i_fifo_empty    = empty;
    i_credit_return = ret;
    for (int c = 0; c < 4; c++) begin
      int cons;
      int sum;
      if (rst) begin
        m_count[c] = 10;
        m_ovf[c]   = 1'b0;
        e.valid[c] = 1'b0;
        e.ready[c] = 1'b0;
        e.low[c]   = 1'b0;
      end else begin
        cons = (!empty[c] && m_count[c] != 0) ? 1 : 0;
        sum  = m_count[c] - cons + int'(ret[c*2 +: 2]);
        if (sum > 10) begin
          sum = 10;
          if (OVF_EN) m_ovf[c] = 1'b1;
        end
        m_count[c] = sum;
        e.valid[c] = (cons == 1);
        e.ready[c] = (sum != 0);
        e.low[c]   = (sum <= 2);
      end
      e.ovf[c]         = m_ovf[c];
      e.count[c*4 +: 4] = 4'(m_count[c]);
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 4'hF, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got_now(), e);
      end
    end
    checks++;
    if (o_ready !== 4'hF || o_credit_count !== 16'hAAAA) begin
      failures++;
      $display("FAIL reset_release ready=%h count=%h exp ready=f count=aaaa", o_ready, o_credit_count);
    end
  endtask

  task automatic test_drain();
    exp_t e;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 4'b1110, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL drain cyc%0d got=%h exp=%h", i, got_now(), e);
      end
      if (o_valid[0]) pulses++;
    end
    checks++;
    if (pulses != 10 || o_ready[0] !== 1'b0 || o_credit_count[3:0] !== 4'd0) begin
      failures++;
      $display("FAIL drain_total pulses=%0d ready0=%b count0=%0d exp 10/0/0", pulses, o_ready[0], o_credit_count[3:0]);
    end
  endtask

  task automatic test_net_zero();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'b1101, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL net_zero_pre cyc%0d got=%h exp=%h", i, got_now(), e);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1101, 8'h04);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e || o_credit_count[7:4] !== 4'd3 || o_valid[1] !== 1'b1) begin
        failures++;
        $display("FAIL net_zero cyc%0d count1=%0d valid1=%b got=%h exp=%h", i, o_credit_count[7:4], o_valid[1], got_now(), e);
      end
    end
  endtask

  task automatic test_zero_return();
    exp_t e;
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 4'b1011, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL zero_drain cyc%0d got=%h exp=%h", i, got_now(), e);
      end
    end
    drive(1'b0, 4'b1011, 8'h20);
    e = exp_q.pop_front();
    checks++;
    if (got_now() !== e || o_valid[2] !== 1'b0 || o_credit_count[11:8] !== 4'd2) begin
      failures++;
      $display("FAIL zero_return valid2=%b count2=%0d exp 0/2", o_valid[2], o_credit_count[11:8]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1011, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e || o_valid[2] !== (i < 2)) begin
        failures++;
        $display("FAIL zero_resume cyc%0d valid2=%b got=%h exp=%h", i, o_valid[2], got_now(), e);
      end
    end
  endtask

  task automatic test_clamp();
    exp_t e;
    drive(1'b0, 4'b0111, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (got_now() !== e || o_credit_count[15:12] !== 4'd9) begin
      failures++;
      $display("FAIL clamp_pre count3=%0d exp 9", o_credit_count[15:12]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'hF, (i == 0) ? 8'hC0 : 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e || o_credit_count[15:12] !== 4'd10 || o_overflow[3] !== OVF_EN) begin
        failures++;
        $display("FAIL clamp cyc%0d count3=%0d ovf3=%b exp 10/%b", i, o_credit_count[15:12], o_overflow[3], OVF_EN);
      end
    end
  endtask

  task automatic test_low();
    exp_t e;
    drive(1'b1, 4'hF, 8'h00);
    void'(exp_q.pop_front());
    drive(1'b0, 4'hF, 8'h00);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1110, 8'h00);
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e || o_low[0] !== (i == 7)) begin
        failures++;
        $display("FAIL low_pop cyc%0d low0=%b count0=%0d got=%h exp=%h", i, o_low[0], o_credit_count[3:0], got_now(), e);
      end
    end
    drive(1'b0, 4'hF, 8'h01);
    e = exp_q.pop_front();
    checks++;
    if (got_now() !== e || o_low[0] !== 1'b0 || o_credit_count[3:0] !== 4'd3) begin
      failures++;
      $display("FAIL low_return low0=%b count0=%0d exp 0/3", o_low[0], o_credit_count[3:0]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 8'($urandom));
      e = exp_q.pop_front();
      checks++;
      if (got_now() !== e) begin
        failures++;
        $display("FAIL burst cyc%0d got=%h exp=%h", i, got_now(), e);
      end
    end
    drive(1'b1, 4'h0, 8'hFF);
    e = exp_q.pop_front();
    checks++;
    if (got_now() !== e || got_now() !== exp_t'({16'h0000, 16'hAAAA})) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", got_now(), e);
    end
    drive(1'b0, 4'hF, 8'h00);
    e = exp_q.pop_front();
    checks++;
    if (got_now() !== e || o_ready !== 4'hF) begin
      failures++;
      $display("FAIL reset_mid_release got=%h exp=%h", got_now(), e);
    end
  endtask

  initial begin
    reset           = 1'b1;
    i_fifo_empty    = 4'hF;
    i_credit_return = 8'h00;
    test_reset();
    test_drain();
    test_net_zero();
    test_zero_return();
    test_clamp();
    test_low();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
